// File: rtl/padd_issue_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// padd_issue_arbiter_pkg
// Shared definitions for the pipelined-adder issue arbiter:
//   - clog2()   : width of a requester ID / round-robin pointer
//   - STAT_W    : width of each per-requester grant counter
//   - STAT_SAT  : value at which a grant counter stops counting
// Optional feature macro used by the top: PADD_ARB_STATS_EN
// ---------------------------------------------------------------------------
package padd_issue_arbiter_pkg;

    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_SAT = 16'hFFFF;

    // Ceiling log2; returns 1 for value==2 so a 2-requester build still
    // gets a one-bit ID.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/padd_issue_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// padd_issue_arbiter_rr_arbiter
// Purely combinational round-robin picker. Searches req starting at ptr and
// wrapping modulo N; the first set bit wins.
// Ports:
//   req   in  N    request vector
//   ptr   in  IDW  highest-priority requester this cycle
//   grant out N    one-hot grant (all zero when req is zero)
//   idx   out IDW  index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module padd_issue_arbiter_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/padd_issue_arbiter.sv
// ---------------------------------------------------------------------------
// padd_issue_arbiter
// Shares one fully pipelined adder (one op per cycle, fixed LATENCY) among N
// requesters. A round-robin grant selects at most one request per cycle and
// muxes its operands onto the adder ports; a valid/ID tag pipeline of the
// adder's depth steers each result back as a one-cycle pulse.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   req_valid/req_ready   per-requester handshake, req_ready is one-hot
//   req_a, req_b, req_cin packed operands, requester i owns slice i
//   rsp_valid             one-hot result pulse to the originating requester
//   rsp_sum, rsp_cout     shared result, meaningful only while rsp_valid!=0
//   add_a/add_b/add_cin/add_en  to the adder
//   add_s/add_c           from the adder
//   stat_grants           N x 16-bit saturating grant counters
// Optional feature: define PADD_ARB_STATS_EN to build the grant counters;
// otherwise stat_grants is tied to zero.
// ---------------------------------------------------------------------------
module padd_issue_arbiter
    import padd_issue_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 4,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_valid,
    output logic [N-1:0]          req_ready,
    input  logic [N*WIDTH-1:0]    req_a,
    input  logic [N*WIDTH-1:0]    req_b,
    input  logic [N-1:0]          req_cin,
    output logic [N-1:0]          rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    output logic                  add_en,
    input  logic [WIDTH-1:0]      add_s,
    input  logic                  add_c,
    output logic [N*STAT_W-1:0]   stat_grants
);

    localparam int IDW = clog2(N);

    logic [IDW-1:0] ptr;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_idx;
    logic           issue;

    logic [LATENCY-1:0] tag_v;
    logic [IDW-1:0]     tag_id [LATENCY];

    padd_issue_arbiter_rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Grants are suppressed while reset is held so nothing handshakes and
    // the adder sees quiet operands.
    assign req_ready = rst ? '0 : grant;
    assign issue     = |req_ready;
    assign add_en    = issue;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (issue) begin
            add_a   = req_a[int'(grant_idx)*WIDTH +: WIDTH];
            add_b   = req_b[int'(grant_idx)*WIDTH +: WIDTH];
            add_cin = req_cin[grant_idx];
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (grant_idx == IDW'(N-1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    // Tag pipeline mirrors the adder depth: entry LATENCY-1 lines up with
    // the adder output, so an op issued in cycle t is at the head in t+LATENCY.
    // The adder has no reset, so this is the only source of result validity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= grant_idx;
            for (int k = 1; k < LATENCY; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tag_v[LATENCY-1]) begin
            rsp_valid[tag_id[LATENCY-1]] = 1'b1;
        end
    end

    assign rsp_sum  = add_s;
    assign rsp_cout = add_c;

`ifdef PADD_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt [N];

    // Per-requester handshake counters, saturating rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i] && grant_cnt[i] != STAT_SAT) begin
                    grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < N; i++) begin
            stat_grants[i*STAT_W +: STAT_W] = grant_cnt[i];
        end
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_padd_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_padd_issue_arbiter
// Self-checking bench for padd_issue_arbiter with N=4, WIDTH=4, LATENCY=4.
// Includes a behavioural, reset-less pipelined adder of the same depth.
// Table-driven per-cycle vectors plus hand sequences for reset mid-flight
// and the grant statistics (PADD_ARB_STATS_EN).
// ---------------------------------------------------------------------------
module tb_padd_issue_arbiter;

    localparam int N       = 4;
    localparam int WIDTH   = 4;
    localparam int LATENCY = 4;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*WIDTH-1:0]  req_a;
    logic [N*WIDTH-1:0]  req_b;
    logic [N-1:0]        req_cin;
    logic [N-1:0]        rsp_valid;
    logic [WIDTH-1:0]    rsp_sum;
    logic                rsp_cout;
    logic [WIDTH-1:0]    add_a;
    logic [WIDTH-1:0]    add_b;
    logic                add_cin;
    logic                add_en;
    logic [WIDTH-1:0]    add_s;
    logic                add_c;
    logic [N*16-1:0]     stat_grants;

    int tests_run;
    int tests_failed;

    padd_issue_arbiter #(
        .N       (N),
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_cin     (req_cin),
        .rsp_valid   (rsp_valid),
        .rsp_sum     (rsp_sum),
        .rsp_cout    (rsp_cout),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_en      (add_en),
        .add_s       (add_s),
        .add_c       (add_c),
        .stat_grants (stat_grants)
    );

    // Pipelined adder: operands sampled every edge, sum appears LATENCY
    // cycles after the operand-drive cycle. No reset, like the real one.
    logic [WIDTH:0] add_pipe [LATENCY];

    always_ff @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);
        for (int k = 1; k < LATENCY; k++) begin
            add_pipe[k] <= add_pipe[k-1];
        end
    end

    assign add_s = add_pipe[LATENCY-1][WIDTH-1:0];
    assign add_c = add_pipe[LATENCY-1][WIDTH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          rst_before;
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  cin;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rsp;
        logic [3:0]  exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit rb, input logic [3:0] v, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] cin,
                           input logic [3:0] er, input logic [3:0] ersp,
                           input logic [3:0] esum, input logic ecout);
        vec_t t;
        t.rst_before = rb;
        t.valid      = v;
        t.a          = a;
        t.b          = b;
        t.cin        = cin;
        t.exp_ready  = er;
        t.exp_rsp    = ersp;
        t.exp_sum    = esum;
        t.exp_cout   = ecout;
        vecs.push_back(t);
    endtask

    task automatic add_idle(input logic [3:0] ersp, input logic [3:0] esum,
                            input logic ecout);
        add_vec(1'b0, 4'b0000, 16'h0, 16'h0, 4'b0, 4'b0000, ersp, esum, ecout);
    endtask

    task automatic checkOutput(input string name, input int row,
                               input logic [63:0] actual, input logic [63:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, row, actual, expected);
        end
    endtask

    // Leaves the bench at posedge+1 with reset released and inputs idle.
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t t);
        if (t.rst_before) begin
            do_reset();
        end
        req_valid = t.valid;
        req_a     = t.a;
        req_b     = t.b;
        req_cin   = t.cin;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        req_valid    = '0;
        req_a        = '0;
        req_b        = '0;
        req_cin      = '0;

        // Single request, then overflow, then pointer wrap.
        add_vec(1'b1, 4'b0001, 16'h0003, 16'h0005, 4'b0000, 4'b0001, 4'b0000, 4'h0, 1'b0);
        add_idle(4'b0000, 4'h0, 1'b0);
        add_idle(4'b0000, 4'h0, 1'b0);
        add_idle(4'b0000, 4'h0, 1'b0);
        add_idle(4'b0001, 4'h8, 1'b0);
        add_idle(4'b0000, 4'h0, 1'b0);
        add_vec(1'b0, 4'b0100, 16'h0F00, 16'h0100, 4'b0100, 4'b0100, 4'b0000, 4'h0, 1'b0);
        add_idle(4'b0000, 4'h0, 1'b0);
        add_idle(4'b0000, 4'h0, 1'b0);
        add_idle(4'b0000, 4'h0, 1'b0);
        add_idle(4'b0100, 4'h1, 1'b1);
        add_vec(1'b0, 4'b1000, 16'h2000, 16'h2000, 4'b0000, 4'b1000, 4'b0000, 4'h0, 1'b0);
        add_vec(1'b0, 4'b0110, 16'h0410, 16'h0410, 4'b0000, 4'b0010, 4'b0000, 4'h0, 1'b0);
        add_vec(1'b0, 4'b0110, 16'h0410, 16'h0410, 4'b0000, 4'b0100, 4'b0000, 4'h0, 1'b0);
        add_idle(4'b0000, 4'h0, 1'b0);
        add_idle(4'b1000, 4'h4, 1'b0);
        add_idle(4'b0010, 4'h2, 1'b0);
        add_idle(4'b0100, 4'h8, 1'b0);
        add_idle(4'b0000, 4'h0, 1'b0);

        // All four valid for 8 cycles from reset.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] er;
            logic [3:0] ersp;
            logic [3:0] esum;
            logic       ecout;
            er    = 4'b0001 << (i % 4);
            ersp  = 4'b0000;
            esum  = 4'h0;
            ecout = 1'b0;
            if (i >= 4) begin
                ersp = 4'b0001 << (i % 4);
                case (i % 4)
                    0:       begin esum = 4'h3; ecout = 1'b0; end
                    1:       begin esum = 4'hB; ecout = 1'b0; end
                    2:       begin esum = 4'h0; ecout = 1'b1; end
                    default: begin esum = 4'hF; ecout = 1'b1; end
                endcase
            end
            add_vec(i == 0, 4'b1111, 16'hF841, 16'hF862, 4'b1010, er, ersp, esum, ecout);
        end
        add_idle(4'b0001, 4'h3, 1'b0);
        add_idle(4'b0010, 4'hB, 1'b0);
        add_idle(4'b0100, 4'h0, 1'b1);
        add_idle(4'b1000, 4'hF, 1'b1);
        add_idle(4'b0000, 4'h0, 1'b0);

        // Reset state with all requests asserted.
        req_valid = 4'b1111;
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        req_cin   = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 0, 64'(req_ready), 64'h0);
        checkOutput("reset_rsp_valid", 0, 64'(rsp_valid), 64'h0);
        checkOutput("reset_add_en", 0, 64'(add_en), 64'h0);
        checkOutput("reset_add_ops", 0, 64'({add_a, add_b, add_cin}), 64'h0);
        @(posedge clk);
        #1;

        for (int r = 0; r < vecs.size(); r++) begin
            applyStimulus(vecs[r]);
            @(negedge clk);
            checkOutput("req_ready", r, 64'(req_ready), 64'(vecs[r].exp_ready));
            checkOutput("add_en", r, 64'(add_en), 64'(|vecs[r].exp_ready));
            checkOutput("rsp_valid", r, 64'(rsp_valid), 64'(vecs[r].exp_rsp));
            if (vecs[r].exp_rsp != 4'b0000) begin
                checkOutput("rsp_sum", r, 64'(rsp_sum), 64'(vecs[r].exp_sum));
                checkOutput("rsp_cout", r, 64'(rsp_cout), 64'(vecs[r].exp_cout));
            end
            next_cycle();
        end

        // Reset mid-flight: three ops issued, reset one cycle later.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0001 << i;
            req_a     = 16'h1111;
            req_b     = 16'h2222;
            @(negedge clk);
            checkOutput("midrst_issue", i, 64'(req_ready), 64'(4'b0001 << i));
            next_cycle();
        end
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_cin   = 4'b1111;
        @(negedge clk);
        checkOutput("midrst_ready", 0, 64'(req_ready), 64'h0);
        checkOutput("midrst_add_en", 0, 64'(add_en), 64'h0);
        checkOutput("midrst_add_ops", 0, 64'({add_a, add_b, add_cin}), 64'h0);
        checkOutput("midrst_rsp", 0, 64'(rsp_valid), 64'h0);
        next_cycle();
        next_cycle();
        rst       = 1'b0;
        req_valid = 4'b0000;
        req_cin   = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("postrst_rsp", i, 64'(rsp_valid), 64'h0);
            next_cycle();
        end
        req_valid = 4'b1110;
        @(negedge clk);
        checkOutput("postrst_first_grant", 0, 64'(req_ready), 64'(4'b0010));
        next_cycle();
        req_valid = 4'b0000;

`ifdef PADD_ARB_STATS_EN
        do_reset();
        req_valid = 4'b0010;
        repeat (70000) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stat_req1_sat", 0, 64'(stat_grants[16 +: 16]), 64'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("stat_req1_hold", 0, 64'(stat_grants[16 +: 16]), 64'hFFFF);
        checkOutput("stat_req0", 0, 64'(stat_grants[0 +: 16]), 64'h0);
        checkOutput("stat_req2_3", 0, 64'(stat_grants[32 +: 32]), 64'h0);
        req_valid = 4'b0000;
`else
        @(negedge clk);
        checkOutput("stat_tied_zero", 0, stat_grants, 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
